mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage integer pipeline. It sits between ex_mem_reg and mem_wb_reg, and its outputs feed the write-back stage through mem_wb_reg.
- Performs loads and stores over a req/gnt/rvalid data-memory bus. Formats load data (sign/zero extension) and passes ALU results straight through.
- Stalls upstream stages while a bus transaction is outstanding.

Parameters:
- AW, 32, data-memory address width.
- DW, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ex_mem_reg_valid_i  in  1  instruction present.
- ex_mem_reg_op_c_i  in  32  ALU result / effective address.
- ex_mem_reg_store_data_i  in  32  rs2 value for stores.
- ex_mem_reg_mem_op_i  in  4  access type: 0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW. Any other code is treated as none.
- ex_mem_reg_reg_waddr_i  in  5  destination register.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  AW  word-aligned address.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  write data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  32  read data.
- mem_op_c_o  out  32  result to mem_wb_reg.
- mem_reg_waddr_o  out  5  destination; 0 = no write-back.
- mem_valid_o  out  1  one-cycle completion pulse.
- mem_stall_o  out  1  to hazard unit; upstream holds its inputs while this is high.

Behaviour:
- Reset values: every output is 0 and the state is IDLE. Reset mid-transaction aborts the transaction:
  - the next cycle has dmem_req_o=0 and mem_stall_o=0;
  - any rvalid or gnt arriving after reset is ignored.
- State IDLE:
  - Accepts when ex_mem_reg_valid_i=1. Latches addr, store data, mem_op and waddr.
  - Non-memory op: mem_op_c_o<=op_c_i, mem_reg_waddr_o<=waddr_i, mem_valid_o<=1. Latency 1 cycle; no stall.
  - Memory op: go to REQ.
- State REQ:
  - Drives dmem_req_o=1, dmem_addr_o={addr[31:2],2'b00}, dmem_we_o=store, plus be/wdata.
  - All bus outputs stay stable until gnt is sampled high.
  - On gnt: a store completes (mem_valid_o<=1, mem_reg_waddr_o<=0, next state IDLE); a load goes to RESP.
  - dmem_req_o drops in the cycle after gnt.
- State RESP:
  - Waits for dmem_rvalid_i. On rvalid: mem_op_c_o<=formatted data, mem_reg_waddr_o<=latched waddr, mem_valid_o<=1, next state IDLE.
  - rvalid in the same cycle as gnt is not possible; rvalid is only sampled in RESP.
- Stall and idle outputs:
  - mem_stall_o = (state!=IDLE), or (state==IDLE and the valid input is a memory op).
  - In any cycle without a completion: mem_valid_o=0 and mem_reg_waddr_o=0 (a bubble write to x0); mem_op_c_o holds its last value.
- Store formatting:
  - SB: be=0001<<addr[1:0]; wdata = byte replicated x4.
  - SH: be = addr[1] ? 1100 : 0011; wdata = half replicated x2.
  - SW: be=1111; wdata = store data.
- Load formatting uses the latched addr[1:0] to select the byte/half. LB/LH sign-extend, LBU/LHU zero-extend, LW passes data through.
- Minimum latency, with gnt immediate: store completes 2 cycles after acceptance; load completes 3 cycles after acceptance if rvalid comes the cycle after gnt. Each wait cycle adds 1.
- Misaligned access without the optional feature: the address's low bits are used as above. A misaligned half or word uses the aligned word; no trap.

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- When defined:
  - adds output mem_misalign_o (1 bit, reset 0);
  - a LH/LHU/SH with addr[0]=1, or a LW/SW with addr[1:0]!=0, issues no bus request;
  - the stage completes in 1 cycle with mem_valid_o=1, mem_reg_waddr_o=0 and mem_misalign_o=1 for that cycle.
- When undefined: no port and no check; behaviour as above.

Test Plan:
- Reset held 2 cycles -> all outputs 0, state IDLE; a late dmem_rvalid_i=1 produces no mem_valid_o.
- ALU op: op_c=0x12345678, waddr=5, mem_op=0000 -> the next cycle gives mem_op_c_o=0x12345678, mem_reg_waddr_o=5, mem_valid_o=1; mem_stall_o stays 0.
- Loads at addr 0x103, rdata=0x80FF0000:
  - LB -> mem_op_c_o=0xFFFFFF80;
  - LBU -> 0x00000080;
  - LH at 0x102 -> 0xFFFF80FF.
- SH at addr 0x202, data 0x0000ABCD, gnt delayed 3 cycles -> dmem_addr_o=0x200, be=1100, wdata=0xABCDABCD held stable 4 cycles; then mem_valid_o=1, mem_reg_waddr_o=0; mem_stall_o high until completion.
- LW in progress, rst asserted while in RESP -> the next cycle has dmem_req_o=0, mem_stall_o=0; rvalid 2 cycles later is ignored.
- With MEM_MISALIGN_CHECK_EN: LW at addr 0x101 -> dmem_req_o never asserted; the next cycle gives mem_misalign_o=1, mem_valid_o=1, mem_reg_waddr_o=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage integer pipeline.
//   Non-memory instructions pass their ALU result through with 1-cycle latency.
//   Loads and stores run over a req/gnt/rvalid bus. The stage stalls upstream
//   while a bus transaction is outstanding.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_mem_reg_*_i           instruction from ex_mem_reg (valid, op_c, store data,
//                            mem_op, destination register)
//   dmem_req/we/addr/be/wdata_o, dmem_gnt/rvalid/rdata_i   data-memory bus
//   mem_op_c_o, mem_reg_waddr_o, mem_valid_o               result to mem_wb_reg
//   mem_stall_o              hold request to the hazard unit
//   mem_misalign_o           misaligned-access flag (only with MEM_MISALIGN_CHECK_EN)
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned half/word
// accesses. Such an access completes in one cycle with no bus request.
module mem_stage #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ex_mem_reg_valid_i,
   input  logic [31:0]   ex_mem_reg_op_c_i,
   input  logic [DW-1:0] ex_mem_reg_store_data_i,
   input  logic [3:0]    ex_mem_reg_mem_op_i,
   input  logic [4:0]    ex_mem_reg_reg_waddr_i,
   output logic          dmem_req_o,
   output logic          dmem_we_o,
   output logic [AW-1:0] dmem_addr_o,
   output logic [3:0]    dmem_be_o,
   output logic [DW-1:0] dmem_wdata_o,
   input  logic          dmem_gnt_i,
   input  logic          dmem_rvalid_i,
   input  logic [DW-1:0] dmem_rdata_i,
`ifdef MEM_MISALIGN_CHECK_EN
   output logic          mem_misalign_o,
`endif
   output logic [31:0]   mem_op_c_o,
   output logic [4:0]    mem_reg_waddr_o,
   output logic          mem_valid_o,
   output logic          mem_stall_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   localparam logic [3:0] OP_LB  = 4'b0001;
   localparam logic [3:0] OP_LH  = 4'b0010;
   localparam logic [3:0] OP_LW  = 4'b0011;
   localparam logic [3:0] OP_LBU = 4'b0100;
   localparam logic [3:0] OP_LHU = 4'b0101;
   localparam logic [3:0] OP_SB  = 4'b1000;
   localparam logic [3:0] OP_SH  = 4'b1001;
   localparam logic [3:0] OP_SW  = 4'b1010;

   function automatic logic is_load(input logic [3:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
      return ((op inside {OP_LH, OP_LHU, OP_SH}) && a[0]) ||
             ((op inside {OP_LW, OP_SW}) && (a != 2'b00));
   endfunction

   // Select byte/half from the returned word and extend to 32 bits.
   function automatic logic [31:0] load_fmt(input logic [3:0] op, input logic [1:0] a,
                                            input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = d[8*a +: 8];
      h = a[1] ? d[31:16] : d[15:0];
      case (op)
         OP_LB:   r = {{24{b[7]}}, b};
         OP_LBU:  r = {24'h0, b};
         OP_LH:   r = {{16{h[15]}}, h};
         OP_LHU:  r = {16'h0, h};
         default: r = d;
      endcase
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] sdata_q, sdata_d;
   logic [3:0]  op_q, op_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] op_c_q, op_c_d;
   logic [4:0]  wb_waddr_q, wb_waddr_d;
   logic        valid_q, valid_d;
   logic        misalign_q, misalign_d;

   logic in_mem;   // incoming instruction will occupy the bus
   logic in_trap;  // incoming instruction is a trapped misaligned access

   always_comb begin
      in_trap = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      in_trap = (is_load(ex_mem_reg_mem_op_i) || is_store(ex_mem_reg_mem_op_i)) &&
                is_misaligned(ex_mem_reg_mem_op_i, ex_mem_reg_op_c_i[1:0]);
`endif
      in_mem = (is_load(ex_mem_reg_mem_op_i) || is_store(ex_mem_reg_mem_op_i)) && !in_trap;
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      sdata_d    = sdata_q;
      op_d       = op_q;
      waddr_d    = waddr_q;
      op_c_d     = op_c_q;       // result holds between completions
      wb_waddr_d = 5'd0;         // bubble writes to x0
      valid_d    = 1'b0;
      misalign_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (ex_mem_reg_valid_i) begin
               addr_d  = ex_mem_reg_op_c_i;
               sdata_d = ex_mem_reg_store_data_i;
               op_d    = ex_mem_reg_mem_op_i;
               waddr_d = ex_mem_reg_reg_waddr_i;
               if (in_mem) begin
                  state_d = REQ;
               end else if (in_trap) begin
                  valid_d    = 1'b1;
                  misalign_d = 1'b1;
               end else begin
                  op_c_d     = ex_mem_reg_op_c_i;
                  wb_waddr_d = ex_mem_reg_reg_waddr_i;
                  valid_d    = 1'b1;
               end
            end
         end
         REQ: begin
            if (dmem_gnt_i) begin
               if (op_q[3]) begin
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (dmem_rvalid_i) begin
               op_c_d     = load_fmt(op_q, addr_q[1:0], dmem_rdata_i);
               wb_waddr_d = waddr_q;
               valid_d    = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         sdata_q    <= '0;
         op_q       <= '0;
         waddr_q    <= '0;
         op_c_q     <= '0;
         wb_waddr_q <= '0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         sdata_q    <= sdata_d;
         op_q       <= op_d;
         waddr_q    <= waddr_d;
         op_c_q     <= op_c_d;
         wb_waddr_q <= wb_waddr_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
      end
   end

   // Bus outputs come only from latched state, so they are stable for the
   // whole REQ phase regardless of what upstream presents meanwhile.
   always_comb begin
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = '0;
      dmem_be_o    = 4'b0000;
      dmem_wdata_o = '0;
      if (state_q == REQ) begin
         dmem_req_o  = 1'b1;
         dmem_we_o   = op_q[3];
         dmem_addr_o = {addr_q[AW-1:2], 2'b00};
         case (op_q)
            OP_SB: begin
               dmem_be_o    = 4'b0001 << addr_q[1:0];
               dmem_wdata_o = {4{sdata_q[7:0]}};
            end
            OP_SH: begin
               dmem_be_o    = addr_q[1] ? 4'b1100 : 4'b0011;
               dmem_wdata_o = {2{sdata_q[15:0]}};
            end
            OP_SW: begin
               dmem_be_o    = 4'b1111;
               dmem_wdata_o = sdata_q;
            end
            default: dmem_be_o = 4'b1111;  // loads fetch the whole word
         endcase
      end
   end

   assign mem_stall_o     = !rst && ((state_q != IDLE) || (ex_mem_reg_valid_i && in_mem));
   assign mem_op_c_o      = op_c_q;
   assign mem_reg_waddr_o = wb_waddr_q;
   assign mem_valid_o     = valid_q;
`ifdef MEM_MISALIGN_CHECK_EN
   assign mem_misalign_o  = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_opc;
   logic [31:0] ex_sd;
   logic [3:0]  ex_op;
   logic [4:0]  ex_wa;
   logic        req, we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt, rvalid;
   logic [31:0] rdata;
   logic [31:0] opc_o;
   logic [4:0]  wa_o;
   logic        valid_o, stall_o;
`ifdef MEM_MISALIGN_CHECK_EN
   logic        mis_o;
`endif

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] exp_opc;

   always #5 clk = ~clk;

   mem_stage #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .ex_mem_reg_valid_i(ex_valid), .ex_mem_reg_op_c_i(ex_opc),
      .ex_mem_reg_store_data_i(ex_sd), .ex_mem_reg_mem_op_i(ex_op),
      .ex_mem_reg_reg_waddr_i(ex_wa),
      .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be),
      .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
      .dmem_rdata_i(rdata),
`ifdef MEM_MISALIGN_CHECK_EN
      .mem_misalign_o(mis_o),
`endif
      .mem_op_c_o(opc_o), .mem_reg_waddr_o(wa_o), .mem_valid_o(valid_o),
      .mem_stall_o(stall_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---- reference model: plain arithmetic on op codes ----
   function automatic bit m_ld(input int op);
      return op >= 1 && op <= 5;
   endfunction
   function automatic bit m_st(input int op);
      return op >= 8 && op <= 10;
   endfunction
   function automatic bit m_mis(input int op, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
      return ((op == 2 || op == 5 || op == 9) && (a % 2 != 0)) ||
             ((op == 3 || op == 10) && (a % 4 != 0));
`else
      return 1'b0;
`endif
   endfunction
   function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] v;
      if (op == 1 || op == 4) begin
         v = (d >> (8 * (a % 4))) & 32'hFF;
         if (op == 1 && v >= 32'd128) v = v | 32'hFFFFFF00;
      end else if (op == 2 || op == 5) begin
         v = (d >> ((a % 4 >= 2) ? 16 : 0)) & 32'hFFFF;
         if (op == 2 && v >= 32'd32768) v = v | 32'hFFFF0000;
      end else begin
         v = d;
      end
      return v;
   endfunction
   function automatic logic [31:0] m_be(input int op, input logic [31:0] a);
      if (op == 8) return 32'd1 << (a % 4);
      if (op == 9) return (a % 4 >= 2) ? 32'hC : 32'h3;
      return 32'hF;
   endfunction
   function automatic logic [31:0] m_wd(input int op, input logic [31:0] d);
      if (op == 8) return (d & 32'hFF) * 32'h01010101;
      if (op == 9) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   // One instruction: present for one cycle, then play the bus with the given
   // grant/response delays and check every cycle through one bubble after.
   task automatic do_txn(input int op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] wa, input int gd, input int rd,
                         input logic [31:0] rdat);
      bit ld, st, mis;
      ld  = m_ld(op);
      st  = m_st(op);
      mis = (ld || st) && m_mis(op, a);
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_op = 4'(op); ex_opc = a; ex_sd = d; ex_wa = wa;
      @(negedge clk);
      chk("stall_accept", 32'(stall_o), 32'((ld || st) && !mis));
      chk("req_accept", 32'(req), 32'd0);
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_opc = $urandom; ex_sd = $urandom; ex_op = 4'($urandom); ex_wa = 5'($urandom);
      if (!(ld || st) || mis) begin
         @(negedge clk);
         if (!mis) exp_opc = a;
         chk("fast_valid", 32'(valid_o), 32'd1);
         chk("fast_opc", opc_o, exp_opc);
         chk("fast_waddr", 32'(wa_o), mis ? 32'd0 : 32'(wa));
         chk("fast_stall", 32'(stall_o), 32'd0);
         chk("fast_req", 32'(req), 32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
         chk("fast_misalign", 32'(mis_o), 32'(mis));
`endif
      end else begin
         for (int i = 0; i <= gd; i++) begin
            @(negedge clk);
            chk("req_req", 32'(req), 32'd1);
            chk("req_we", 32'(we), 32'(st));
            chk("req_addr", addr, a & ~32'd3);
            if (st) begin
               chk("req_be", 32'(be), m_be(op, a));
               chk("req_wdata", wdata, m_wd(op, d));
            end
            chk("req_stall", 32'(stall_o), 32'd1);
            chk("req_valid", 32'(valid_o), 32'd0);
            gnt = (i == gd);
            @(posedge clk); #1;
            gnt = 1'b0;
         end
         if (ld) begin
            for (int j = 0; j <= rd; j++) begin
               @(negedge clk);
               chk("resp_req", 32'(req), 32'd0);
               chk("resp_stall", 32'(stall_o), 32'd1);
               chk("resp_valid", 32'(valid_o), 32'd0);
               rvalid = (j == rd);
               rdata  = (j == rd) ? rdat : $urandom;
               @(posedge clk); #1;
               rvalid = 1'b0;
            end
         end
         @(negedge clk);
         if (ld) exp_opc = m_load(op, a, rdat);
         chk("done_valid", 32'(valid_o), 32'd1);
         chk("done_opc", opc_o, exp_opc);
         chk("done_waddr", 32'(wa_o), ld ? 32'(wa) : 32'd0);
         chk("done_req", 32'(req), 32'd0);
         chk("done_stall", 32'(stall_o), 32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
         chk("done_misalign", 32'(mis_o), 32'd0);
`endif
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("bubble_valid", 32'(valid_o), 32'd0);
      chk("bubble_waddr", 32'(wa_o), 32'd0);
      chk("bubble_opc", opc_o, exp_opc);
   endtask

   initial begin
      rst = 1'b1; ex_valid = 1'b0; ex_opc = '0; ex_sd = '0; ex_op = '0; ex_wa = '0;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      exp_opc = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_addr", addr, 32'd0);
      chk("rst_be", 32'(be), 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_opc", opc_o, 32'd0);
      chk("rst_waddr", 32'(wa_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      rst = 1'b0;
      // late bus responses after reset must be ignored
      @(posedge clk); #1; rvalid = 1'b1; gnt = 1'b1;
      @(posedge clk); #1; rvalid = 1'b0; gnt = 1'b0;
      @(negedge clk);
      chk("late_rvalid_valid", 32'(valid_o), 32'd0);
      chk("late_rvalid_req", 32'(req), 32'd0);

      // directed cases
      do_txn(0, 32'h12345678, 32'h0, 5'd5, 0, 0, 32'h0);
      chk("alu_plan", opc_o, 32'h12345678);
      do_txn(1, 32'h103, 32'h0, 5'd1, 0, 0, 32'h80FF0000);
      chk("lb_plan", opc_o, 32'hFFFFFF80);
      do_txn(4, 32'h103, 32'h0, 5'd2, 1, 2, 32'h80FF0000);
      chk("lbu_plan", opc_o, 32'h00000080);
      do_txn(2, 32'h102, 32'h0, 5'd3, 0, 1, 32'h80FF0000);
      chk("lh_plan", opc_o, 32'hFFFF80FF);
      do_txn(9, 32'h202, 32'h0000ABCD, 5'd7, 3, 0, 32'h0);
      do_txn(3, 32'h101, 32'h0, 5'd4, 0, 0, 32'hCAFEF00D);
      do_txn(10, 32'h402, 32'h11223344, 5'd8, 1, 0, 32'h0);

      // reset while a load waits in RESP
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_op = 4'b0011; ex_opc = 32'h300; ex_wa = 5'd9;
      @(posedge clk); #1; ex_valid = 1'b0;
      @(negedge clk); gnt = 1'b1;
      @(posedge clk); #1; gnt = 1'b0;
      @(negedge clk);
      chk("resp_pre_rst_stall", 32'(stall_o), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("abort_req", 32'(req), 32'd0);
      chk("abort_stall", 32'(stall_o), 32'd0);
      chk("abort_valid", 32'(valid_o), 32'd0);
      exp_opc = '0;
      @(posedge clk); #1; rvalid = 1'b1; rdata = 32'hDEADBEEF;
      @(posedge clk); #1; rvalid = 1'b0;
      @(negedge clk);
      chk("abort_rvalid_valid", 32'(valid_o), 32'd0);
      chk("abort_rvalid_waddr", 32'(wa_o), 32'd0);
      chk("abort_rvalid_opc", opc_o, exp_opc);

      // random traffic
      for (int k = 0; k < 150; k++) begin
         do_txn(int'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
